// File: rtl/seq_divider_40_20.sv
// rtl/seq_divider_40_20.sv - unsigned 40/20 restoring divider, one quotient bit per clock
//
// seq_divider_40_20: multi-cycle restoring divider with valid/ready on both sides.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor    operands, sampled on accept
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   quotient, remainder  result, held stable while out_valid && !out_ready
//   div_by_zero          set with the result when the divisor was zero
//
// adder_40_bit: 40-bit carry-lookahead adder (4-bit lookahead groups).
//   a_i, b_i, cin_i      addends and carry in
//   sum_o, cout_o        sum and carry out

module adder_40_bit (
  input  logic [39:0] a_i,
  input  logic [39:0] b_i,
  input  logic        cin_i,
  output logic [39:0] sum_o,
  output logic        cout_o
);

  logic [39:0] g;
  logic [39:0] p;
  logic        c0;
  logic        c1;
  logic        c2;
  logic        c3;
  logic [3:0]  g4;
  logic [3:0]  p4;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carries inside each group come straight from the group carry-in; the
  // group carry-out uses group generate/propagate.
  always_comb begin
    sum_o = '0;
    c0    = cin_i;
    c1    = 1'b0;
    c2    = 1'b0;
    c3    = 1'b0;
    g4    = '0;
    p4    = '0;
    for (int k = 0; k < 10; k++) begin
      g4 = g[4*k +: 4];
      p4 = p[4*k +: 4];
      c1 = g4[0] | (p4[0] & c0);
      c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
      c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
         | (p4[2] & p4[1] & p4[0] & c0);
      sum_o[4*k +: 4] = p4 ^ {c3, c2, c1, c0};
      c0 = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & c0);
    end
    cout_o = c0;
  end

endmodule

module seq_divider_40_20 #(
  parameter int DVD_W = 40,
  parameter int DVS_W = 20,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DVD_W-1:0]   q_q, q_d;
  logic [DVS_W:0]     r_q, r_d;
  logic [DVS_W-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;

  logic [DVS_W:0]     shifted;
  logic [39:0]        add_a;
  logic [39:0]        add_b;
  logic [39:0]        add_sum;
  logic               add_cout;
  logic               borrow;
  logic               unused_hi;

  // Trial subtraction S - divisor done as S + ~divisor + 1 on the wide adder.
  assign shifted = {r_q[DVS_W-1:0], q_q[DVD_W-1]};
  assign add_a   = {{(40-DVS_W-1){1'b0}}, shifted};
  assign add_b   = ~{{(40-DVS_W){1'b0}}, dvs_q};
  assign borrow  = ~add_cout;

  adder_40_bit u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (1'b1),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // The partial remainder never reaches 2^DVS_W, so its top bit and the
  // upper adder bits carry no information.
  assign unused_hi = ^{add_sum[39:DVS_W+1], r_q[DVS_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          r_d   = '0;
          cnt_d = CNT_W'(DVD_W - 1);
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, dividend[DVS_W-1:0]};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dividend;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d = borrow ? shifted : add_sum[DVS_W:0];
        q_d = {q_q[DVD_W-2:0], ~borrow};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q[DVS_W-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_40_20.sv
// tb/tb_seq_divider_40_20.sv - self-checking bench for seq_divider_40_20
module tb_seq_divider_40_20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] dividend;
  logic [19:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] quotient;
  logic [19:0] remainder;
  logic        div_by_zero;

  always #5 clk = ~clk;

  seq_divider_40_20 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [39:0] q;
    logic [19:0] r;
    logic        z;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [39:0] a, input logic [19:0] b);
    res_t m;
    if (b == 20'd0) begin
      m.q = 40'hFF_FFFF_FFFF;
      m.r = a[19:0];
      m.z = 1'b1;
    end else begin
      logic [39:0] rr;
      m.q = a / {20'd0, b};
      rr  = a % {20'd0, b};
      m.r = rr[19:0];
      m.z = 1'b0;
    end
    return m;
  endfunction

  // Scoreboard: every cycle a result is offered it must match the oldest
  // outstanding expectation; it is retired on the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        chk("sb_quotient", {24'd0, quotient}, {24'd0, exp_q[0].q});
        chk("sb_remainder", {44'd0, remainder}, {44'd0, exp_q[0].r});
        chk("sb_dbz", {63'd0, div_by_zero}, {63'd0, exp_q[0].z});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [39:0] a, input logic [19:0] b,
                      input bit lit, input logic [39:0] lq, input logic [19:0] lr, input bit lz,
                      input int hold, input int abort_at);
    int lat;
    logic [63:0] prod;
    @(posedge clk); #1;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = 20'($urandom);
    lat = (b == 20'd0) ? 1 : 40;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k < lat) begin
        in_valid = (k % 3 == 0);
        dividend = {$urandom, $urandom};
        divisor  = 20'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("abort_quotient", {24'd0, quotient}, 64'd0);
        chk("abort_remainder", {44'd0, remainder}, 64'd0);
        chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        return;
      end
      if (k < lat) begin
        chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
        chk("early_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
      end
    end
    if (lit) begin
      chk("lit_quotient", {24'd0, quotient}, {24'd0, lq});
      chk("lit_remainder", {44'd0, remainder}, {44'd0, lr});
      chk("lit_dbz", {63'd0, div_by_zero}, {63'd0, lz});
    end
    if (b != 20'd0) begin
      prod = {24'd0, quotient} * {44'd0, b} + {44'd0, remainder};
      chk("invariant_product", prod, {24'd0, a});
      chk("invariant_rem_lt", {63'd0, (remainder < b)}, 64'd1);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = h[0];
      dividend = {$urandom, $urandom};
      divisor  = 20'($urandom);
      @(negedge clk);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_out_valid", {63'd0, out_valid}, 64'd0);
    chk("after_hs_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    res_t m;
    logic [19:0] fa;
    logic [19:0] fb;
    logic [39:0] ra;
    logic [19:0] rb;
    int sel;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_quotient", {24'd0, quotient}, 64'd0);
    chk("reset_remainder", {44'd0, remainder}, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;

    m = model(40'd1_000_000, 20'd7);
    chk("model_basic_q", {24'd0, m.q}, 64'd142857);
    chk("model_basic_r", {44'd0, m.r}, 64'd1);
    m = model(40'hFF_FFFF_FFFF, 20'hFFFFF);
    chk("model_ext_q", {24'd0, m.q}, 64'h10_0001);
    m = model(40'h12345, 20'd0);
    chk("model_dbz", {24'd0, m.q, m.z}, {24'd0, 40'hFF_FFFF_FFFF, 1'b1});

    send(40'd1_000_000, 20'd7, 1, 40'd142857, 20'd1, 1'b0, 0, 0);
    send(40'hFF_FFFF_FFFF, 20'hFFFFF, 1, 40'h10_0001, 20'd0, 1'b0, 0, 0);
    send(40'hFF_FFFF_FFFF, 20'd1, 1, 40'hFF_FFFF_FFFF, 20'd0, 1'b0, 0, 0);
    send(40'h12345, 20'd0, 1, 40'hFF_FFFF_FFFF, 20'h12345, 1'b1, 0, 0);
    send(40'd5, 20'd9, 1, 40'd0, 20'd5, 1'b0, 0, 0);
    send(40'd1234567, 20'd1000, 1, 40'd1234, 20'd567, 1'b0, 10, 0);
    send(40'hABCDE12345, 20'h1F, 0, 40'd0, 20'd0, 1'b0, 0, 20);
    send(40'd100, 20'd10, 1, 40'd10, 20'd0, 1'b0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        ra = {$urandom, $urandom};
        send(ra, 20'd0, 1, 40'hFF_FFFF_FFFF, ra[19:0], 1'b1, i % 3, 0);
      end else if (sel <= 3) begin
        fa = 20'($urandom);
        fb = 20'($urandom);
        if (fb == 20'd0) fb = 20'd3;
        ra = {20'd0, fa} * {20'd0, fb};
        send(ra, fb, 1, {20'd0, fa}, 20'd0, 1'b0, i % 3, 0);
      end else begin
        ra = {$urandom, $urandom};
        if (sel == 4) ra = ra >> $urandom_range(0, 39);
        rb = 20'($urandom) >> $urandom_range(0, 19);
        if (rb == 20'd0) rb = 20'd1;
        send(ra, rb, 0, 40'd0, 20'd0, 1'b0, i % 3, 0);
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
